xm_resolve_latch: RTL and testbench

- Execute-to-memory boundary stage, directly downstream of the 32-bit ALU in the 5-stage pipeline.
- Consumes the ALU's data_result, isNotEqual, isLessThan and overflow.
- Resolves branches and jumps combinationally, and rewrites overflowing add/addi/sub into rstatus writes to $r30.
- Registers the instruction into the X/M latch, with stall-hold, flush-bubble, and a saturating exception counter.

---
 rtl/xm_resolve_latch.sv | 175 +++++++++++++++++
 tb/tb_xm_resolve_latch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/xm_resolve_latch.sv
// Execute-to-memory boundary: resolves branches/jumps combinationally, rewrites
// overflowing add/addi/sub into rstatus writes, and registers the X/M latch.
module xm_resolve_latch #(
   parameter int EXC_CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 x_valid,
   input  logic [4:0]           x_opcode,
   input  logic [4:0]           x_aluop,
   input  logic [4:0]           x_rd,
   input  logic [31:0]          x_result,
   input  logic                 x_isNotEqual,
   input  logic                 x_isLessThan,
   input  logic                 x_overflow,
   input  logic [31:0]          x_pc1,
   input  logic [31:0]          x_target,
   input  logic [31:0]          x_store_data,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 branch_taken,
   output logic [31:0]          branch_pc,
   output logic                 m_valid,
   output logic [4:0]           m_opcode,
   output logic [4:0]           m_rd,
   output logic [31:0]          m_result,
   output logic [31:0]          m_store_data,
   output logic                 m_we,
   output logic [EXC_CNT_W-1:0] exc_count
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;

   localparam logic [EXC_CNT_W-1:0] EXC_MAX = '1;

   // Opcode decode
   logic is_rtype, is_addi, is_sw, is_lw, is_bne, is_blt;
   logic is_j, is_jal, is_jr, is_bex, is_setx;
   logic is_add, is_sub;

   always_comb begin
      is_rtype = (x_opcode == OP_RTYPE);
      is_addi  = (x_opcode == OP_ADDI);
      is_sw    = (x_opcode == OP_SW);
      is_lw    = (x_opcode == OP_LW);
      is_bne   = (x_opcode == OP_BNE);
      is_blt   = (x_opcode == OP_BLT);
      is_j     = (x_opcode == OP_J);
      is_jal   = (x_opcode == OP_JAL);
      is_jr    = (x_opcode == OP_JR);
      is_bex   = (x_opcode == OP_BEX);
      is_setx  = (x_opcode == OP_SETX);
      is_add   = is_rtype && (x_aluop == ALU_ADD);
      is_sub   = is_rtype && (x_aluop == ALU_SUB);
   end

   // Branch resolution
   logic fire;
   logic redirect;

   always_comb begin
      fire     = x_valid && !stall && !flush;
      redirect = (is_bne && x_isNotEqual) || (is_blt && x_isLessThan) ||
                 is_j || is_jal || is_jr || (is_bex && x_isNotEqual);
      branch_taken = fire && redirect;
      branch_pc    = branch_taken ? x_target : 32'd0;
   end

   // Write-back field computation, including the overflow rewrite
   logic        rewrite;
   logic [4:0]  wr_rd;
   logic [31:0] wr_result;
   logic        wr_we;

   always_comb begin
      rewrite   = x_overflow && (is_add || is_addi || is_sub);
      wr_rd     = x_rd;
      wr_result = x_result;
      wr_we     = is_rtype || is_addi || is_lw || is_jal || is_setx;
      if (rewrite) begin
         wr_rd = 5'd30;
         if (is_add)
            wr_result = 32'd1;
         else if (is_addi)
            wr_result = 32'd2;
         else
            wr_result = 32'd3;
      end else if (is_jal) begin
         wr_rd     = 5'd31;
         wr_result = x_pc1;
      end else if (is_setx) begin
         wr_rd     = 5'd30;
         wr_result = x_target;
      end
   end

   // X/M latch
   logic                 m_valid_q, m_valid_d;
   logic [4:0]           m_opcode_q, m_opcode_d;
   logic [4:0]           m_rd_q, m_rd_d;
   logic [31:0]          m_result_q, m_result_d;
   logic [31:0]          m_store_data_q, m_store_data_d;
   logic                 m_we_q, m_we_d;
   logic [EXC_CNT_W-1:0] exc_count_q, exc_count_d;

   always_comb begin
      m_valid_d      = m_valid_q;
      m_opcode_d     = m_opcode_q;
      m_rd_d         = m_rd_q;
      m_result_d     = m_result_q;
      m_store_data_d = m_store_data_q;
      m_we_d         = m_we_q;
      exc_count_d    = exc_count_q;
      if (flush) begin
         m_valid_d      = 1'b0;
         m_opcode_d     = 5'd0;
         m_rd_d         = 5'd0;
         m_result_d     = 32'd0;
         m_store_data_d = 32'd0;
         m_we_d         = 1'b0;
      end else if (!stall) begin
         m_valid_d      = x_valid;
         m_opcode_d     = x_opcode;
         m_rd_d         = wr_rd;
         m_result_d     = wr_result;
         m_store_data_d = is_sw ? x_store_data : x_store_data;
         m_we_d         = x_valid && wr_we;
         // Counter saturates rather than wrapping
         if (x_valid && rewrite && (exc_count_q != EXC_MAX))
            exc_count_d = exc_count_q + EXC_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_valid_q      <= 1'b0;
         m_opcode_q     <= 5'd0;
         m_rd_q         <= 5'd0;
         m_result_q     <= 32'd0;
         m_store_data_q <= 32'd0;
         m_we_q         <= 1'b0;
         exc_count_q    <= '0;
      end else begin
         m_valid_q      <= m_valid_d;
         m_opcode_q     <= m_opcode_d;
         m_rd_q         <= m_rd_d;
         m_result_q     <= m_result_d;
         m_store_data_q <= m_store_data_d;
         m_we_q         <= m_we_d;
         exc_count_q    <= exc_count_d;
      end
   end

   assign m_valid      = m_valid_q;
   assign m_opcode     = m_opcode_q;
   assign m_rd         = m_rd_q;
   assign m_result     = m_result_q;
   assign m_store_data = m_store_data_q;
   assign m_we         = m_we_q;
   assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_xm_resolve_latch.sv
// Directed bench for xm_resolve_latch: default-width instance for function,
// a 2-bit-counter instance for saturation.
module tb_xm_resolve_latch;

   logic        clock;
   logic        reset, reset_sat;
   logic        x_valid;
   logic [4:0]  x_opcode, x_aluop, x_rd;
   logic [31:0] x_result, x_pc1, x_target, x_store_data;
   logic        x_isNotEqual, x_isLessThan, x_overflow;
   logic        stall, flush;

   logic        branch_taken, s_branch_taken;
   logic [31:0] branch_pc, s_branch_pc;
   logic        m_valid, s_m_valid;
   logic [4:0]  m_opcode, s_m_opcode, m_rd, s_m_rd;
   logic [31:0] m_result, s_m_result, m_store_data, s_m_store_data;
   logic        m_we, s_m_we;
   logic [7:0]  exc_count;
   logic [1:0]  s_exc_count;

   int n_cmp = 0;
   int n_err = 0;

   xm_resolve_latch #(.EXC_CNT_W(8)) dut (
      .clock(clock), .reset(reset), .x_valid(x_valid), .x_opcode(x_opcode),
      .x_aluop(x_aluop), .x_rd(x_rd), .x_result(x_result),
      .x_isNotEqual(x_isNotEqual), .x_isLessThan(x_isLessThan),
      .x_overflow(x_overflow), .x_pc1(x_pc1), .x_target(x_target),
      .x_store_data(x_store_data), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_pc(branch_pc), .m_valid(m_valid),
      .m_opcode(m_opcode), .m_rd(m_rd), .m_result(m_result),
      .m_store_data(m_store_data), .m_we(m_we), .exc_count(exc_count)
   );

   xm_resolve_latch #(.EXC_CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset_sat), .x_valid(x_valid), .x_opcode(x_opcode),
      .x_aluop(x_aluop), .x_rd(x_rd), .x_result(x_result),
      .x_isNotEqual(x_isNotEqual), .x_isLessThan(x_isLessThan),
      .x_overflow(x_overflow), .x_pc1(x_pc1), .x_target(x_target),
      .x_store_data(x_store_data), .stall(stall), .flush(flush),
      .branch_taken(s_branch_taken), .branch_pc(s_branch_pc), .m_valid(s_m_valid),
      .m_opcode(s_m_opcode), .m_rd(s_m_rd), .m_result(s_m_result),
      .m_store_data(s_m_store_data), .m_we(s_m_we), .exc_count(s_exc_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %-14s 0x%08h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      x_valid = 1'b0; x_opcode = 5'd0; x_aluop = 5'd0; x_rd = 5'd0;
      x_result = 32'd0; x_isNotEqual = 1'b0; x_isLessThan = 1'b0;
      x_overflow = 1'b0; x_pc1 = 32'd0; x_target = 32'd0; x_store_data = 32'd0;
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] rd,
                        input logic [31:0] res, input logic ovf);
      x_valid = 1'b1; x_opcode = op; x_aluop = aop; x_rd = rd;
      x_result = res; x_overflow = ovf;
      x_isNotEqual = 1'b0; x_isLessThan = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      reset_sat = 1'b0;
      step();
      step();
      check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
      check_eq("rst_exc", {24'd0, exc_count}, 32'd0);
      reset = 1'b1;

      // add overflow: 0x7FFFFFFF + 1 wraps to 0x80000000
      drive(5'b00000, 5'b00000, 5'd5, 32'h8000_0000, 1'b1);
      step();
      check_eq("add_ovf_rd", {27'd0, m_rd}, 32'd30);
      check_eq("add_ovf_res", m_result, 32'd1);
      check_eq("add_ovf_we", {31'd0, m_we}, 32'd1);
      check_eq("add_ovf_exc", {24'd0, exc_count}, 32'd1);

      drive(5'b00101, 5'b00000, 5'd6, 32'h8000_0000, 1'b1);
      step();
      check_eq("addi_ovf_res", m_result, 32'd2);
      check_eq("addi_ovf_exc", {24'd0, exc_count}, 32'd2);

      drive(5'b00000, 5'b00001, 5'd7, 32'h7FFF_FFFF, 1'b1);
      step();
      check_eq("sub_ovf_rd", {27'd0, m_rd}, 32'd30);
      check_eq("sub_ovf_res", m_result, 32'd3);
      check_eq("sub_ovf_exc", {24'd0, exc_count}, 32'd3);

      // overflow on lw is ignored
      drive(5'b01000, 5'b00000, 5'd9, 32'h0000_00AB, 1'b1);
      step();
      check_eq("lw_rd", {27'd0, m_rd}, 32'd9);
      check_eq("lw_res", m_result, 32'h0000_00AB);
      check_eq("lw_exc", {24'd0, exc_count}, 32'd3);

      // bne taken
      drive(5'b00010, 5'b00000, 5'd3, 32'd0, 1'b0);
      x_isNotEqual = 1'b1; x_target = 32'h40;
      #1;
      check_eq("bne_taken", {31'd0, branch_taken}, 32'd1);
      check_eq("bne_pc", branch_pc, 32'h40);
      step();
      check_eq("bne_we", {31'd0, m_we}, 32'd0);
      check_eq("bne_valid", {31'd0, m_valid}, 32'd1);

      x_isNotEqual = 1'b0;
      #1;
      check_eq("bne_nt", {31'd0, branch_taken}, 32'd0);
      check_eq("bne_nt_pc", branch_pc, 32'd0);

      drive(5'b00110, 5'b00000, 5'd3, 32'd0, 1'b0);
      x_isLessThan = 1'b1; x_target = 32'h24;
      #1;
      check_eq("blt_taken", {31'd0, branch_taken}, 32'd1);
      check_eq("blt_pc", branch_pc, 32'h24);

      drive(5'b10110, 5'b00000, 5'd0, 32'd0, 1'b0);
      x_isNotEqual = 1'b1; x_target = 32'h99;
      #1;
      check_eq("bex_taken", {31'd0, branch_taken}, 32'd1);

      // jal
      drive(5'b00011, 5'b00000, 5'd2, 32'h1234, 1'b0);
      x_pc1 = 32'h11; x_target = 32'h80;
      #1;
      check_eq("jal_taken", {31'd0, branch_taken}, 32'd1);
      check_eq("jal_pc", branch_pc, 32'h80);
      step();
      check_eq("jal_rd", {27'd0, m_rd}, 32'd31);
      check_eq("jal_res", m_result, 32'h11);
      check_eq("jal_we", {31'd0, m_we}, 32'd1);

      // setx writes target into $r30, no redirect
      drive(5'b10101, 5'b00000, 5'd4, 32'h5, 1'b0);
      x_target = 32'h777;
      #1;
      check_eq("setx_nt", {31'd0, branch_taken}, 32'd0);
      step();
      check_eq("setx_rd", {27'd0, m_rd}, 32'd30);
      check_eq("setx_res", m_result, 32'h777);

      drive(5'b00111, 5'b00000, 5'd8, 32'h100, 1'b0);
      x_store_data = 32'hCAFE_F00D;
      step();
      check_eq("sw_data", m_store_data, 32'hCAFE_F00D);
      check_eq("sw_we", {31'd0, m_we}, 32'd0);

      // stall holds the latch while inputs change
      drive(5'b00000, 5'b00000, 5'd9, 32'h55, 1'b0);
      step();
      check_eq("pre_stall", m_result, 32'h55);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(5'b00011, 5'b00000, 5'd1, 32'h1000 + i, 1'b0);
         x_pc1 = 32'h200 + i; x_target = 32'h300;
         #1;
         check_eq("stall_bt", {31'd0, branch_taken}, 32'd0);
         step();
         check_eq("stall_res", m_result, 32'h55);
         check_eq("stall_rd", {27'd0, m_rd}, 32'd9);
      end
      drive(5'b00000, 5'b00000, 5'd1, 32'h8000_0000, 1'b1);
      flush = 1'b1;
      step();
      check_eq("flush_valid", {31'd0, m_valid}, 32'd0);
      check_eq("flush_we", {31'd0, m_we}, 32'd0);
      check_eq("flush_exc", {24'd0, exc_count}, 32'd3);
      stall = 1'b0; flush = 1'b0;

      // async reset away from the edge
      drive(5'b00000, 5'b00000, 5'd5, 32'h8000_0000, 1'b1);
      step();
      check_eq("pre_rst_valid", {31'd0, m_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, m_valid}, 32'd0);
      check_eq("arst_result", m_result, 32'd0);
      check_eq("arst_exc", {24'd0, exc_count}, 32'd0);
      reset = 1'b1;
      step();
      check_eq("post_rst_exc", {24'd0, exc_count}, 32'd1);

      // saturation on the 2-bit counter instance
      reset_sat = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] exp_sat;
         exp_sat = (i < 3) ? (i + 1) : 3;
         drive(5'b00000, 5'b00000, 5'd5, 32'h8000_0000, 1'b1);
         step();
         check_eq("sat_exc", {30'd0, s_exc_count}, exp_sat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
